pc_sequencer: RTL and testbench

Fetch/execute sequencer and program-counter unit for the 4-bit-opcode CPU. It consumes the control word produced by the control logic (PS, IL) and returns the `state` and `opcode` that the control logic decodes. It owns the fetch/execute state bit, the program counter, the instruction register and a small hardware return-address stack for jump-and-link/return. It sits between instruction memory (combinational read) and the control logic.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/ret_stack.sv | 50 +++++
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 4-bit-opcode CPU: PC-select codes, sequencer
// states and the opcodes the sequencer handles itself.
package cpu_pkg;

    localparam int unsigned OPC_W = 4;

    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_INC  = 2'b01,
        PS_BR   = 2'b10,
        PS_RET  = 2'b11
    } ps_e;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_e;

    localparam logic [OPC_W-1:0] OP_JAL = 4'b1101;
    localparam logic [OPC_W-1:0] OP_RET = 4'b1111;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO with a registered top-of-stack copy.
// Pushes when full and pops when empty are ignored; the caller flags them.
module ret_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full_c,
    output logic             o_empty_c
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_top;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full_c  = (r_cnt == CNT_W'(DEPTH));
    assign o_empty_c = (r_cnt == '0);
    assign w_do_push = i_push && !o_full_c;
    assign w_do_pop  = i_pop && !o_empty_c && !i_push;
    assign o_top     = r_top;

    // r_top always mirrors r_mem[r_cnt-1] so a pop needs no read mux at the caller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_top <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_cnt[IDX_W-1:0]] <= i_data;
            r_cnt                   <= r_cnt + CNT_W'(1);
            r_top                   <= i_data;
        end else if (w_do_pop) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_top <= (r_cnt >= CNT_W'(2)) ? r_mem[IDX_W'(r_cnt - CNT_W'(2))] : '0;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: owns state bit, PC, IR and the return stack.
// Fetch edge loads IR, execute edge updates PC from PS or JAL/return.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned IR_W      = 16,
    parameter int unsigned OFF_W     = 8,
    parameter int unsigned RET_DEPTH = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [1:0]       PS,
    input  logic             IL,
    input  logic [IR_W-1:0]  instr_data,
    output logic [PC_W-1:0]  pc,
    output logic [IR_W-1:0]  ir,
    output logic [OPC_W-1:0] opcode,
    output logic             state,
    output logic             ret_err
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [IR_W-1:0]   r_ir;
    logic [IR_W-1:0]   w_ir_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              w_push;
    logic              w_pop;
    logic [PC_W-1:0]   w_top;
    logic              w_full;
    logic              w_empty;
    logic [OPC_W-1:0]  w_opcode;
    logic [PC_W-1:0]   w_off;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_pc_br;

    assign w_opcode = r_ir[IR_W-1 -: OPC_W];
    // signed cast sign-extends a short offset and truncates a long one
    assign w_off    = PC_W'($signed(r_ir[OFF_W-1:0]));
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_pc_br  = r_pc + w_off;

    ret_stack #(
        .DEPTH (RET_DEPTH),
        .WIDTH (PC_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (w_pc_inc),
        .o_top     (w_top),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_pc    <= PC_W'(RESET_PC);
            r_ir    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        if (run) begin
            case (r_state)
                ST_FETCH: begin
                    w_state_nxt = ST_EXEC;
                    if (IL) begin
                        w_ir_nxt = instr_data;
                    end
                end
                ST_EXEC: begin
                    w_state_nxt = ST_FETCH;
                    if (w_opcode == OP_JAL) begin
                        // JAL overrides PS; a full stack drops the link but still jumps
                        w_push   = 1'b1;
                        w_pc_nxt = w_pc_br;
                        if (w_full) begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        case (PS)
                            PS_HOLD: w_pc_nxt = r_pc;
                            PS_INC:  w_pc_nxt = w_pc_inc;
                            PS_BR:   w_pc_nxt = w_pc_br;
                            PS_RET: begin
                                if (w_empty) begin
                                    w_pc_nxt  = w_pc_inc;
                                    w_err_nxt = 1'b1;
                                end else begin
                                    w_pop    = 1'b1;
                                    w_pc_nxt = w_top;
                                end
                            end
                            default: w_pc_nxt = r_pc;
                        endcase
                    end
                end
                default: w_state_nxt = ST_FETCH;
            endcase
        end
    end

    assign pc      = r_pc;
    assign ir      = r_ir;
    assign opcode  = w_opcode;
    assign state   = r_state;
    assign ret_err = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the bench plays control logic and
// instruction memory, and checks PC/IR/state/ret_err after each edge.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [1:0]  PS;
    logic        IL;
    logic [15:0] instr_data;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic        state;
    logic        ret_err;

    logic [15:0] imem [256];
    logic        use_ovr;
    logic [15:0] ovr_data;
    int          n_checks;
    int          n_pass;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] INC  = 2'b01;
    localparam logic [1:0] BR   = 2'b10;
    localparam logic [1:0] RET  = 2'b11;

    pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .PS         (PS),
        .IL         (IL),
        .instr_data (instr_data),
        .pc         (pc),
        .ir         (ir),
        .opcode     (opcode),
        .state      (state),
        .ret_err    (ret_err)
    );

    assign instr_data = use_ovr ? ovr_data : imem[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full instruction: fetch with IL=1, execute with the given PS
    task automatic do_instr(input string tag, input logic [1:0] ps, input logic [7:0] exp_pc);
        run = 1'b1;
        IL  = 1'b1;
        PS  = ps;
        tick();
        check({tag, " fetch state"}, 32'(state), 32'd1);
        tick();
        check({tag, " pc"}, 32'(pc), 32'(exp_pc));
        check({tag, " exec state"}, 32'(state), 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        use_ovr  = 1'b0;
        ovr_data = '0;
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'h2000;
        end
        rst_n = 1'b0;
        run   = 1'b0;
        PS    = HOLD;
        IL    = 1'b0;
        #1;
        check("rst pc", 32'(pc), 32'h0);
        check("rst state", 32'(state), 32'd0);
        check("rst ir", 32'(ir), 32'h0);
        check("rst err", 32'(ret_err), 32'd0);
        check("rst opcode", 32'(opcode), 32'h0);
        #2;
        rst_n = 1'b1;

        // straight-line ALU ops, PS=INC
        imem[0] = 16'h2001;
        imem[1] = 16'h2002;
        run = 1'b1;
        IL  = 1'b1;
        PS  = INC;
        tick();
        check("seq0 pc", 32'(pc), 32'h0);
        check("seq0 state", 32'(state), 32'd1);
        check("seq0 ir", 32'(ir), 32'h2001);
        check("seq0 opcode", 32'(opcode), 32'h2);
        tick();
        check("seq1 pc", 32'(pc), 32'h1);
        check("seq1 state", 32'(state), 32'd0);
        tick();
        check("seq2 pc", 32'(pc), 32'h1);
        check("seq2 ir", 32'(ir), 32'h2002);
        tick();
        check("seq3 pc", 32'(pc), 32'h2);
        do_instr("inc2", INC, 8'h03);
        do_instr("inc3", INC, 8'h04);
        do_instr("inc4", INC, 8'h05);

        // backward branch, then forward branch with wrap
        imem[5] = 16'h20FC;
        do_instr("br back", BR, 8'h01);
        imem[1] = 16'h20EF;
        do_instr("br fwd", BR, 8'hF0);
        imem[8'hF0] = 16'h207F;
        do_instr("br wrap", BR, 8'h6F);

        // IL=0 on fetch keeps ir
        IL = 1'b0;
        PS = INC;
        tick();
        check("noil ir", 32'(ir), 32'h207F);
        tick();
        check("noil pc", 32'(pc), 32'h70);

        // JAL ignores PS, return pops the link
        pulse_reset();
        imem[0] = 16'h2003;
        do_instr("to3", BR, 8'h03);
        imem[8'h03] = 16'hD010;
        do_instr("jal", HOLD, 8'h13);
        imem[8'h13] = 16'hF000;
        do_instr("ret", RET, 8'h04);
        check("ret err", 32'(ret_err), 32'd0);

        // five nested JALs: fifth overflows but still jumps
        imem[8'h04] = 16'hD010;
        imem[8'h14] = 16'hD010;
        imem[8'h24] = 16'hD010;
        imem[8'h34] = 16'hD010;
        imem[8'h44] = 16'hD010;
        do_instr("jal1", RET, 8'h14);
        do_instr("jal2", HOLD, 8'h24);
        do_instr("jal3", BR, 8'h34);
        do_instr("jal4", RET, 8'h44);
        check("full err", 32'(ret_err), 32'd0);
        do_instr("jal5", RET, 8'h54);
        check("ovf err", 32'(ret_err), 32'd1);
        imem[8'h54] = 16'hF000;
        imem[8'h35] = 16'hF000;
        imem[8'h25] = 16'hF000;
        imem[8'h15] = 16'hF000;
        do_instr("pop1", RET, 8'h35);
        do_instr("pop2", RET, 8'h25);
        do_instr("pop3", RET, 8'h15);
        do_instr("pop4", RET, 8'h05);

        // pop on empty stack
        pulse_reset();
        check("clr err", 32'(ret_err), 32'd0);
        imem[0] = 16'h2009;
        do_instr("to9", BR, 8'h09);
        imem[8'h09] = 16'hF000;
        do_instr("ret empty", RET, 8'h0A);
        check("unf err", 32'(ret_err), 32'd1);

        // run=0 freezes an instruction mid-way
        imem[8'h0A] = 16'h3055;
        run = 1'b1;
        IL  = 1'b1;
        PS  = INC;
        tick();
        check("frz fetch ir", 32'(ir), 32'h3055);
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("frz pc", 32'(pc), 32'h0A);
            check("frz ir", 32'(ir), 32'h3055);
            check("frz state", 32'(state), 32'd1);
        end
        use_ovr  = 1'b1;
        ovr_data = 16'hBEEF;
        run = 1'b1;
        tick();
        use_ovr = 1'b0;
        check("resume pc", 32'(pc), 32'h0B);
        check("resume state", 32'(state), 32'd0);
        check("exec ir", 32'(ir), 32'h3055);
        check("sticky err", 32'(ret_err), 32'd1);

        // async reset mid-execute
        tick();
        check("pre rst state", 32'(state), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async pc", 32'(pc), 32'h0);
        check("async state", 32'(state), 32'd0);
        check("async ir", 32'(ir), 32'h0);
        check("async err", 32'(ret_err), 32'd0);
        rst_n = 1'b1;
        do_instr("post rst", INC, 8'h01);
        check("post rst ir", 32'(ir), 32'h2009);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
